// File: rtl/sub_bytes_iter.sv
// Iterative AES forward SubBytes: one 128-bit state in, BYTES_PER_CYCLE bytes
// substituted per clock, result held on a valid/ready output until consumed.
module sub_bytes_iter #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int unsigned N_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int unsigned GRP_W   = 8 * BYTES_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    // Lane count must divide the 16-byte state into a power-of-two number of steps
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
        $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[2047 - 8 * int'(x) -: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       in_q, in_d;
    logic [127:0]       res_q, res_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [GRP_W-1:0]   grp_in;
    logic [GRP_W-1:0]   grp_out;

    assign grp_in = in_q[int'(cnt_q) * GRP_W +: GRP_W];

    // Replicated S-box lanes over the current byte group
    for (genvar l = 0; l < int'(BYTES_PER_CYCLE); l++) begin : g_lane
        assign grp_out[l*8 +: 8] = sbox(grp_in[l*8 +: 8]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_d    = state_in;
                    cnt_d   = '0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                res_d[int'(cnt_q) * GRP_W +: GRP_W] = grp_out;
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d == S_SUB);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_q        <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_q        <= in_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = res_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter: main B=4 instance plus B=1/2/8/16
// instances for latency of the FIPS-197 round-1 vector.
module tb_sub_bytes_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    logic         x_valid;
    logic [127:0] x_data;
    logic         x_oready;
    logic [3:0]   x_ir;
    logic [3:0]   x_ov;
    logic [3:0]   x_busy;
    logic [127:0] x_so [4];

    int           n_checks;
    int           n_errors;
    int           cyc;
    int           n_out;
    int           acc_cyc;
    bit           ov_seen;
    logic [127:0] sb[$];
    int           acc_log[$];
    logic [7:0]   inv_tab [256];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    // Reference table, row = high nibble, column = low nibble (col 0 in MSB)
    localparam logic [127:0] SB_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy)
    );

    sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ir[0]),
        .state_in(x_data), .out_valid(x_ov[0]), .out_ready(x_oready),
        .state_out(x_so[0]), .busy(x_busy[0])
    );
    sub_bytes_iter #(.BYTES_PER_CYCLE(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ir[1]),
        .state_in(x_data), .out_valid(x_ov[1]), .out_ready(x_oready),
        .state_out(x_so[1]), .busy(x_busy[1])
    );
    sub_bytes_iter #(.BYTES_PER_CYCLE(8)) u_b8 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ir[2]),
        .state_in(x_data), .out_valid(x_ov[2]), .out_ready(x_oready),
        .state_out(x_so[2]), .busy(x_busy[2])
    );
    sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_b16 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ir[3]),
        .state_in(x_data), .out_valid(x_ov[3]), .out_ready(x_oready),
        .state_out(x_so[3]), .busy(x_busy[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_s(input logic [7:0] x);
        logic [127:0] row;
        row = SB_ROW[x[7:4]];
        return row[127 - 8 * int'(x[3:0]) -: 8];
    endfunction

    function automatic logic [127:0] ref_blk(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_s(s[8*i +: 8]);
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observes the main DUT at the falling edge; handshakes complete on the next rise
    task automatic monitor();
        if (!rst_n) begin
            sb.delete();
            ov_seen = 1'b0;
            return;
        end
        if (in_valid && in_ready) begin
            sb.push_back(ref_blk(state_in));
            acc_cyc = cyc + 1;
            acc_log.push_back(cyc + 1);
        end
        if (out_valid && !ov_seen) begin
            ov_seen = 1'b1;
            check_eq("latency_b4", 128'(cyc - acc_cyc), 128'(4));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check_eq("sb_underflow", 128'(1), 128'(0));
            else check_eq("sb_data", state_out, sb.pop_front());
            ov_seen = 1'b0;
            n_out++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic wait_out(input int target);
        for (int k = 0; k < 60 && n_out < target; k++) step();
        if (n_out < target) check_eq("out_timeout", 128'(n_out), 128'(target));
    endtask

    task automatic run_block(input logic [127:0] data);
        int t;
        t        = n_out;
        in_valid = 1'b1;
        state_in = data;
        step();
        in_valid = 1'b0;
        wait_out(t + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  128'(in_ready),  128'(1));
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_busy"},      128'(busy),      128'(0));
        check_eq({tag, "_state_out"}, state_out,       128'h0);
    endtask

    task automatic test_multi_lane();
        int           lat [4];
        int           exp_lat [4];
        logic [127:0] got [4];
        exp_lat = '{16, 8, 2, 1};
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1;
            got[i] = '0;
        end
        x_data  = FIPS_IN;
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
        x_data  = '1;
        for (int k = 1; k <= 24; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (x_ov[i] && lat[i] < 0) begin
                    lat[i] = k;
                    got[i] = x_so[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("latency_lane%0d", i), 128'(lat[i]), 128'(exp_lat[i]));
            check_eq($sformatf("fips_lane%0d", i), got[i], FIPS_OUT);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic [127:0] e;
        d         = 128'h00112233445566778899aabbccddeeff;
        e         = ref_blk(d);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        state_in  = d;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) step();
        check_eq("bp_reach_done", 128'(out_valid), 128'(1));
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            state_in = ~d;
            step();
            check_eq("bp_out_valid", 128'(out_valid), 128'(1));
            check_eq("bp_in_ready",  128'(in_ready),  128'(0));
            check_eq("bp_state_out", state_out,       e);
        end
        check_eq("bp_no_accept", 128'(sb.size()), 128'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("bp_release_in_ready", 128'(in_ready), 128'(1));
        check_eq("bp_release_valid", 128'(out_valid), 128'(0));
        check_eq("bp_sb_drained", 128'(sb.size()), 128'(0));
    endtask

    task automatic test_back_to_back();
        logic [127:0] d [3];
        int           t;
        int           j;
        d[0] = 128'h0f0e0d0c0b0a09080706050403020100;
        d[1] = 128'hdeadbeefcafef00d0123456789abcdef;
        d[2] = 128'h5a5aa5a5c3c33c3c9696696912345678;
        acc_log.delete();
        t        = n_out;
        j        = 0;
        in_valid = 1'b1;
        state_in = d[0];
        for (int k = 0; k < 60 && acc_log.size() < 3; k++) begin
            step();
            if (acc_log.size() > j) begin
                j = acc_log.size();
                if (j < 3) state_in = d[j];
            end
        end
        in_valid = 1'b0;
        wait_out(t + 3);
        check_eq("b2b_accepts", 128'(acc_log.size()), 128'(3));
        if (acc_log.size() == 3) begin
            check_eq("b2b_gap0", 128'(acc_log[1] - acc_log[0]), 128'(6));
            check_eq("b2b_gap1", 128'(acc_log[2] - acc_log[1]), 128'(6));
        end
        check_eq("b2b_last", state_out, ref_blk(d[2]));
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] rec;
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        n_out     = 0;
        acc_cyc   = 0;
        ov_seen   = 1'b0;
        for (int i = 0; i < 256; i++) inv_tab[ref_s(8'(i))] = 8'(i);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        state_in  = '0;
        out_ready = 1'b1;
        x_valid   = 1'b0;
        x_data    = '0;
        x_oready  = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        check_reset_outputs("reset");
        check_eq("reset_lanes_ready", 128'(x_ir), 128'(4'hf));
        check_eq("reset_lanes_valid", 128'(x_ov), 128'(4'h0));

        // Single-byte vectors with known table values
        run_block({96'h0, 32'hff530100});
        check_eq("single_bytes", state_out, {{12{8'h63}}, 32'h16ed7c63});

        run_block(FIPS_IN);
        check_eq("fips_b4", state_out, FIPS_OUT);

        test_multi_lane();
        test_backpressure();

        // Input changes after accept must not leak into the result
        v        = 128'h3243f6a8885a308d313198a2e0370734;
        in_valid = 1'b1;
        state_in = v;
        step();
        in_valid = 1'b0;
        state_in = '1;
        wait_out(n_out + 1);
        check_eq("stability", state_out, ref_blk(v));

        test_back_to_back();

        // Reset while in SUB with the counter at step 2
        in_valid = 1'b1;
        state_in = 128'hffeeddccbbaa99887766554433221100;
        step();
        in_valid = 1'b0;
        step();
        step();
        check_eq("midrst_busy_before", 128'(busy), 128'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        check_eq("midrst_sb_cleared", 128'(sb.size()), 128'(0));
        run_block(FIPS_IN);
        check_eq("after_reset", state_out, FIPS_OUT);

        // Every byte value through the S-box, then back through the inverse
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'(16 * j + i);
            run_block(v);
            for (int i = 0; i < 16; i++) rec[8*i +: 8] = inv_tab[state_out[8*i +: 8]];
            check_eq($sformatf("inverse_blk%0d", j), rec, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
